// File: rtl/exponent_to_linear.sv
// Decodes an 8-bit sign/exponent/significand sample into a two's-complement
// linear value, shifting the significand one bit per clock.
module exponent_to_linear #(
  parameter int EXP_W     = 3,
  parameter int SIG_W     = 4,
  parameter int OUT_W     = 12,
  parameter int RECON_MID = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exponent,
  input  logic [SIG_W-1:0] in_signif,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_linear,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [OUT_W-1:0] mag_q;
  logic [OUT_W-1:0] bias_q;
  logic [EXP_W-1:0] cnt_q;
  logic             sign_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_linear_q;
  logic             in_ready_q;
  logic             busy_q;

  logic [OUT_W-1:0] bias_d;
  logic [OUT_W-1:0] recon_d;
  logic [OUT_W-1:0] linear_d;

  // Half-step bias restores the midpoint of the bits the encoder truncated.
  always_comb begin
    bias_d = '0;
    if (RECON_MID != 0 && in_exponent != '0) begin
      bias_d = OUT_W'(1) << (in_exponent - EXP_W'(1));
    end
  end

  always_comb begin
    recon_d  = mag_q + bias_q;
    linear_d = sign_q ? -recon_d : recon_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mag_q        <= '0;
      bias_q       <= '0;
      cnt_q        <= '0;
      sign_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_linear_q <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q      <= OUT_W'(in_signif);
            cnt_q      <= in_exponent;
            sign_q     <= in_sign;
            bias_q     <= bias_d;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q - EXP_W'(1);
          end else begin
            out_linear_q <= linear_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_linear = out_linear_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_exponent_to_linear.sv
// Bench for exponent_to_linear: two instances (without and with midpoint
// reconstruction) checked every cycle against a latency/arithmetic model.
module tb_exponent_to_linear;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inSign = 1'b0;
  logic [2:0]  inExponent = '0;
  logic [3:0]  inSignif = '0;
  logic        outReady = 1'b0;

  logic        inReady0, outValid0, busy0;
  logic        inReady1, outValid1, busy1;
  logic [11:0] outLinear0, outLinear1;

  int checks = 0;
  int failures = 0;

  logic        mIdle;
  logic        mValid;
  int          mRemain;
  logic [11:0] mPend0, mPend1, mLin0, mLin1;

  always #5 clk = ~clk;

  exponent_to_linear #(.EXP_W(3), .SIG_W(4), .OUT_W(12), .RECON_MID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady0),
    .in_sign(inSign), .in_exponent(inExponent), .in_signif(inSignif),
    .out_valid(outValid0), .out_ready(outReady), .out_linear(outLinear0), .busy(busy0)
  );

  exponent_to_linear #(.EXP_W(3), .SIG_W(4), .OUT_W(12), .RECON_MID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady1),
    .in_sign(inSign), .in_exponent(inExponent), .in_signif(inSignif),
    .out_valid(outValid1), .out_ready(outReady), .out_linear(outLinear1), .busy(busy1)
  );

  function automatic logic [11:0] refLinear(input logic s, input int e, input int sig, input int recon);
    int r;
    int v;
    r = (sig << e) + ((recon != 0 && e > 0) ? (1 << (e - 1)) : 0);
    v = s ? -r : r;
    return v[11:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a word accepted while idle produces its result E+1 clocks later
  // and holds it until the consumer takes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIdle   <= 1'b1;
      mValid  <= 1'b0;
      mRemain <= 0;
      mPend0  <= '0;
      mPend1  <= '0;
      mLin0   <= '0;
      mLin1   <= '0;
    end else if (mIdle) begin
      if (inValid) begin
        mIdle   <= 1'b0;
        mRemain <= int'(inExponent) + 1;
        mPend0  <= refLinear(inSign, int'(inExponent), int'(inSignif), 0);
        mPend1  <= refLinear(inSign, int'(inExponent), int'(inSignif), 1);
      end
    end else if (!mValid) begin
      if (mRemain == 1) begin
        mValid <= 1'b1;
        mLin0  <= mPend0;
        mLin1  <= mPend1;
      end else begin
        mRemain <= mRemain - 1;
      end
    end else if (outReady) begin
      mValid <= 1'b0;
      mIdle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready0", inReady0, mIdle);
      checkOutput("busy1", busy1, !mIdle);
      checkOutput("out_valid0", outValid0, mValid);
      checkOutput("out_valid1", outValid1, mValid);
      if (mValid) begin
        checkOutput("out_linear0", outLinear0, mLin0);
        checkOutput("out_linear1", outLinear1, mLin1);
      end
    end
  end

  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while (!inReady0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!inReady0) checkOutput("wait_in_ready_timeout", 0, 1);
  endtask

  // Drives one word, measures latency, checks literal results and backpressure.
  task automatic applyStimulus(input logic s, input logic [2:0] e, input logic [3:0] sig,
                               input logic [11:0] lit0, input logic [11:0] lit1, input int hold);
    int lat = 0;
    logic [11:0] held0;
    waitIdle();
    inValid = 1'b1; inSign = s; inExponent = e; inSignif = sig; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!outValid0 && lat < 20);
    checkOutput("latency", lat, int'(e) + 1);
    checkOutput("literal0", outLinear0, lit0);
    checkOutput("literal1", outLinear1, lit1);
    held0 = outLinear0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      inValid = 1'b1; inSign = ~s; inExponent = 3'd1; inSignif = 4'd1;
      @(posedge clk); #1;
      checkOutput("hold_stable", outLinear0, held0);
      checkOutput("hold_in_ready", inReady1, 0);
    end
    @(negedge clk);
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("released_valid", outValid1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    checkOutput("rst_out_valid", outValid0, 0);
    checkOutput("rst_out_linear", outLinear1, 0);
    checkOutput("rst_in_ready", inReady0, 1);
    checkOutput("rst_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 3'd0, 4'd5,  12'h005, 12'h005, 0);
    applyStimulus(1'b1, 3'd7, 4'd15, 12'h880, 12'h840, 0);
    applyStimulus(1'b0, 3'd7, 4'd15, 12'h780, 12'h7C0, 5);
    applyStimulus(1'b0, 3'd3, 4'd10, 12'h050, 12'h054, 0);
    applyStimulus(1'b1, 3'd0, 4'd3,  12'hFFD, 12'hFFD, 0);
    applyStimulus(1'b1, 3'd5, 4'd0,  12'h000, 12'hFF0, 0);

    // Abort mid-conversion with an asynchronous reset.
    waitIdle();
    inValid = 1'b1; inSign = 1'b0; inExponent = 3'd6; inSignif = 4'd9;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    checkOutput("pre_abort_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", outValid0, 0);
    checkOutput("abort_out_linear", outLinear0, 0);
    checkOutput("abort_in_ready", inReady1, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back words with the consumer always ready.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      outReady = 1'b1;
      inSign = 1'($urandom_range(0, 1));
      inExponent = 3'($urandom_range(0, 7));
      inSignif = 4'($urandom_range(0, 15));
    end

    // Randomised valid/ready traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      inValid = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      inSign = 1'($urandom_range(0, 1));
      inExponent = 3'($urandom_range(0, 7));
      inSignif = 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
